control_pio_ctrl: RTL and testbench
===================================

Name: control_pio_ctrl

Overview:
- Avalon-MM controller for the 4-bit control input port (switches/buttons) read by the NIOS2 core.
- Sits between the raw board pins and the CPU bus:
  - synchronises and debounces each input bit;
  - detects edges, latches them in an edge-capture register, and raises a maskable interrupt.
- Lets firmware configure debounce time and edge type instead of polling raw pins.

Parameters:
- WIDTH, 4, number of input bits.
- CNT_W, 20, debounce counter width.
- DB_DEFAULT, 50000, reset value of the debounce reload register (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_port  in  WIDTH  raw asynchronous pin inputs.
- address  in  3  Avalon register word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered, fixed latency 1.
- irq  out  1  level interrupt to CPU.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port reset. Everything below samples reset on the rising clk edge.
- Reset values:
  - readdata=0, irq=0
  - sync stages=0, stable=0, counters=0
  - edgecap=0, irqmask=0, edgesel=2'b01, dbreload=DB_DEFAULT
- Synchroniser:
  - Two flops per bit: sync = in_port delayed 2 cycles.
- Debounce, per bit i:
  - If sync[i]==stable[i]: cnt[i] <= 0.
  - Otherwise cnt[i] increments each cycle.
  - When cnt[i]==dbreload-1 and the mismatch persists: stable[i] <= sync[i] and cnt[i] <= 0 in the same cycle.
  - dbreload==0 bypasses debounce: stable <= sync every cycle.
  - Any glitch shorter than dbreload cycles clears the counter and is ignored.
- Edge detect: compare stable to its previous-cycle value, stable_d.
  - edgesel=01: rising only.
  - edgesel=10: falling only.
  - edgesel=11: both.
  - edgesel=00: none.
  - Detected edge sets edgecap[i] in the cycle after stable changes.
- Register map (word addresses):
  - 0 DATA, RO: stable[WIDTH-1:0], zero-extended.
  - 1 RAW, RO: sync[WIDTH-1:0].
  - 2 IRQMASK, RW: bits [WIDTH-1:0].
  - 3 EDGECAP, RW1C: writing 1 to a bit clears it; writing 0 has no effect.
  - 4 EDGESEL, RW: bits [1:0].
  - 5 DBRELOAD, RW: bits [CNT_W-1:0].
  - 6–7: read 0, writes ignored.
- Unused readdata bits are always 0. Unused writedata bits are ignored.
- Read path: readdata <= mux(address) every cycle, so it is valid the cycle after address/read are presented. read is not required for the mux. No read side effects.
- Write path: a write takes effect on the clock edge where write=1. The new value is visible on readdata 2 cycles after the write cycle if the address is held.
- Simultaneous edge set and W1C clear on the same bit: set wins, so edgecap stays 1.
- DBRELOAD written while a counter is running: the new value applies immediately. If cnt ≥ new reload-1, stable updates on the next mismatch cycle.
- irq <= |(edgecap & irqmask), registered, one cycle after edgecap/irqmask change.
- Counter wrap: cnt saturates at 2^CNT_W-1 and never wraps.
- Reset mid-debounce: all state returns to reset values. A pin held high through reset is re-debounced from stable=0 and produces a rising edge after dbreload cycles.
- read and write asserted together: the write is performed, and readdata shows the pre-write value in the next cycle.

Test Plan:
1. Reset, then read addresses 0,2,3,4,5 → 0, 0, 0, 0x1, 50000. Check irq=0.
2. DBRELOAD=8, in_port 0→0x5 held for 20 cycles → DATA reads 0x5 exactly 2+8 cycles after the pin change (±1 for the edge cycle). EDGECAP=0x5.
3. DBRELOAD=8, bit0 pulse of 5 cycles → DATA stays 0x0 and EDGECAP stays 0.
4. IRQMASK=0x1, EDGESEL=0x3, toggle bit0 high then low with DBRELOAD=0 → EDGECAP[0]=1 and irq=1 after the first edge. Write 0x1 to addr 3 → irq=0 one cycle later, then re-set on the falling edge.
5. Same-cycle edge on bit1 and W1C of bit1 → EDGECAP[1] remains 1.
6. Assert reset for 1 cycle during an in-progress debounce (cnt=5 of 8) → all registers return to reset values. With the pin still high, DATA becomes 1 after a full debounce using DBRELOAD=50000, or with a bench-shortened DB_DEFAULT override.

Source files
------------

// File: rtl/control_pio_ctrl_if.sv
//------------------------------------------------------------------------------
// control_pio_ctrl_if
//
// Avalon-MM slave bus bundle for the control PIO register block.
//
// Signals:
//   address   [2:0]   register word address
//   read              read strobe (readdata is produced every cycle regardless)
//   write             write strobe, takes effect on the clock edge it is high
//   writedata [31:0]  write data
//   readdata  [31:0]  registered read data, fixed latency of one cycle
//
// Modports:
//   master  - the CPU side (drives address/read/write/writedata)
//   slave   - the register block (drives readdata)
//------------------------------------------------------------------------------
interface control_pio_ctrl_if;

   logic [2:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output read,
      output write,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  read,
      input  write,
      input  writedata,
      output readdata
   );

endinterface : control_pio_ctrl_if

// File: rtl/control_pio_ctrl.sv
//------------------------------------------------------------------------------
// control_pio_ctrl
//
// Avalon-MM controller for the board's control input pins (switches and
// buttons). Each pin is brought into the clk domain through a two-flop
// synchroniser, debounced by a per-bit counter, edge-detected, and latched in
// an edge-capture register that can raise a maskable level interrupt.
//
// Ports:
//   clk      in   system clock, all logic on the rising edge
//   reset    in   synchronous active-high reset
//   in_port  in   WIDTH raw asynchronous pin inputs
//   bus      slave Avalon-MM register bus (address/read/write/writedata/readdata)
//   irq      out  level interrupt, |(edgecap & irqmask), registered
//
// Register map (word address):
//   0 DATA      RO    debounced pin state
//   1 RAW       RO    synchronised, un-debounced pin state
//   2 IRQMASK   RW    per-bit interrupt enable
//   3 EDGECAP   RW1C  captured edges; write 1 to clear a bit
//   4 EDGESEL   RW    [0] rising, [1] falling
//   5 DBRELOAD  RW    debounce length in cycles; 0 bypasses the debounce
//   6-7               read as 0, writes ignored
//------------------------------------------------------------------------------
module control_pio_ctrl #(
   parameter int WIDTH      = 4,
   parameter int CNT_W      = 20,
   parameter int DB_DEFAULT = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   control_pio_ctrl_if.slave bus,
   output logic             irq
);

   localparam logic [CNT_W-1:0] DB_INIT = CNT_W'(DB_DEFAULT);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_RAW      = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
   localparam logic [2:0] ADDR_EDGESEL  = 3'd4;
   localparam logic [2:0] ADDR_DBRELOAD = 3'd5;

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;
   logic [WIDTH-1:0] stable_reg;
   logic [WIDTH-1:0] stable_d_reg;
   logic [CNT_W-1:0] cnt_reg [WIDTH];

   logic [WIDTH-1:0] irqmask_reg;
   logic [WIDTH-1:0] edgecap_reg;
   logic [1:0]       edgesel_reg;
   logic [CNT_W-1:0] dbreload_reg;

   logic [31:0]      readdata_reg;
   logic             irq_reg;

   //---------------------------------------------------------------------------
   // Next-state signals
   //---------------------------------------------------------------------------
   logic [WIDTH-1:0] stable_next;
   logic [CNT_W-1:0] cnt_next [WIDTH];
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] w1c_mask;
   logic [WIDTH-1:0] edgecap_next;
   logic [31:0]      readdata_next;

   logic             wr_irqmask;
   logic             wr_edgecap;
   logic             wr_edgesel;
   logic             wr_dbreload;

   // The read strobe and upper writedata bits carry no meaning for this block.
   logic             unused_bits;
   assign unused_bits = &{1'b0, bus.read, bus.writedata[31:CNT_W]};

   //---------------------------------------------------------------------------
   // Debounce, one counter per bit.
   // The terminal test is ">=" rather than "==" so that shrinking DBRELOAD
   // below a running count still releases the bit on the next mismatch cycle
   // instead of waiting for the counter to saturate.
   //---------------------------------------------------------------------------
   logic [CNT_W-1:0] db_limit;
   assign db_limit = dbreload_reg - CNT_W'(1);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
         always_comb begin
            stable_next[gi] = stable_reg[gi];
            cnt_next[gi]    = cnt_reg[gi];
            if (dbreload_reg == '0) begin
               stable_next[gi] = sync2_reg[gi];
               cnt_next[gi]    = '0;
            end else if (sync2_reg[gi] == stable_reg[gi]) begin
               cnt_next[gi] = '0;
            end else if (cnt_reg[gi] >= db_limit) begin
               stable_next[gi] = sync2_reg[gi];
               cnt_next[gi]    = '0;
            end else if (cnt_reg[gi] != CNT_MAX) begin
               cnt_next[gi] = cnt_reg[gi] + CNT_W'(1);
            end
         end
      end
   endgenerate

   //---------------------------------------------------------------------------
   // Edge detection against the previous debounced value
   //---------------------------------------------------------------------------
   assign edge_det = ({WIDTH{edgesel_reg[0]}} & stable_reg & ~stable_d_reg) |
                     ({WIDTH{edgesel_reg[1]}} & ~stable_reg & stable_d_reg);

   //---------------------------------------------------------------------------
   // Register write decode
   //---------------------------------------------------------------------------
   assign wr_irqmask  = bus.write && (bus.address == ADDR_IRQMASK);
   assign wr_edgecap  = bus.write && (bus.address == ADDR_EDGECAP);
   assign wr_edgesel  = bus.write && (bus.address == ADDR_EDGESEL);
   assign wr_dbreload = bus.write && (bus.address == ADDR_DBRELOAD);

   assign w1c_mask = wr_edgecap ? bus.writedata[WIDTH-1:0] : '0;

   // Set is ORed in after the clear so a new edge always survives a
   // simultaneous W1C of the same bit.
   assign edgecap_next = (edgecap_reg & ~w1c_mask) | edge_det;

   //---------------------------------------------------------------------------
   // Read mux, sampled every cycle from the current (pre-write) state
   //---------------------------------------------------------------------------
   always_comb begin
      readdata_next = '0;
      case (bus.address)
         ADDR_DATA:     readdata_next[WIDTH-1:0] = stable_reg;
         ADDR_RAW:      readdata_next[WIDTH-1:0] = sync2_reg;
         ADDR_IRQMASK:  readdata_next[WIDTH-1:0] = irqmask_reg;
         ADDR_EDGECAP:  readdata_next[WIDTH-1:0] = edgecap_reg;
         ADDR_EDGESEL:  readdata_next[1:0]       = edgesel_reg;
         ADDR_DBRELOAD: readdata_next[CNT_W-1:0] = dbreload_reg;
         default:       readdata_next = '0;
      endcase
   end

   //---------------------------------------------------------------------------
   // Sequential state
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg    <= '0;
         sync2_reg    <= '0;
         stable_reg   <= '0;
         stable_d_reg <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_reg[i] <= '0;
         end
         irqmask_reg  <= '0;
         edgecap_reg  <= '0;
         edgesel_reg  <= 2'b01;
         dbreload_reg <= DB_INIT;
         readdata_reg <= '0;
         irq_reg      <= 1'b0;
      end else begin
         sync1_reg    <= in_port;
         sync2_reg    <= sync1_reg;
         stable_reg   <= stable_next;
         stable_d_reg <= stable_reg;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_reg[i] <= cnt_next[i];
         end
         edgecap_reg  <= edgecap_next;
         if (wr_irqmask) begin
            irqmask_reg <= bus.writedata[WIDTH-1:0];
         end
         if (wr_edgesel) begin
            edgesel_reg <= bus.writedata[1:0];
         end
         if (wr_dbreload) begin
            dbreload_reg <= bus.writedata[CNT_W-1:0];
         end
         readdata_reg <= readdata_next;
         irq_reg      <= |(edgecap_reg & irqmask_reg);
      end
   end

   assign bus.readdata = readdata_reg;
   assign irq          = irq_reg;

endmodule : control_pio_ctrl

// File: tb/tb_control_pio_ctrl.sv
//------------------------------------------------------------------------------
// tb_control_pio_ctrl
//
// Register-map vectors from a table, then directed sequences for debounce
// timing, glitch rejection, interrupt set/clear, set-vs-clear priority and
// reset in the middle of a debounce.
//------------------------------------------------------------------------------
module tb_control_pio_ctrl;

   localparam int WIDTH      = 4;
   localparam int CNT_W      = 20;
   localparam int DB_DEFAULT = 50000;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] in_port = '0;
   logic             irq;

   control_pio_ctrl_if bus_if ();

   control_pio_ctrl #(
      .WIDTH      (WIDTH),
      .CNT_W      (CNT_W),
      .DB_DEFAULT (DB_DEFAULT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in_port (in_port),
      .bus     (bus_if.slave),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          wr;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vec [NVEC];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
      end else begin
         $display("ok   %s = 0x%08h", name, got);
      end
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      bus_if.address   = a;
      bus_if.writedata = d;
      bus_if.write     = 1'b1;
      tick();
      bus_if.write     = 1'b0;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
      bus_if.address = a;
      bus_if.read    = 1'b1;
      tick();
      bus_if.read    = 1'b0;
      d = bus_if.readdata;
   endtask

   task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(a, d);
      check(name, d, exp);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [31:0] d;
      int          c0;
      int          lat;
      bit          found;

      bus_if.address   = '0;
      bus_if.read      = 1'b0;
      bus_if.write     = 1'b0;
      bus_if.writedata = '0;

      // Register-map vectors. Write entries also assert read: readdata after
      // the write edge must still show the pre-write value.
      vec[0]  = '{1'b0, 3'd0, 32'h0,          32'h0};
      vec[1]  = '{1'b0, 3'd1, 32'h0,          32'h0};
      vec[2]  = '{1'b0, 3'd2, 32'h0,          32'h0};
      vec[3]  = '{1'b0, 3'd3, 32'h0,          32'h0};
      vec[4]  = '{1'b0, 3'd4, 32'h0,          32'h1};
      vec[5]  = '{1'b0, 3'd5, 32'h0,          32'd50000};
      vec[6]  = '{1'b0, 3'd6, 32'h0,          32'h0};
      vec[7]  = '{1'b0, 3'd7, 32'h0,          32'h0};
      vec[8]  = '{1'b1, 3'd2, 32'hFFFF_FFFA,  32'h0};
      vec[9]  = '{1'b0, 3'd2, 32'h0,          32'hA};
      vec[10] = '{1'b1, 3'd4, 32'hFFFF_FFFE,  32'h1};
      vec[11] = '{1'b0, 3'd4, 32'h0,          32'h2};
      vec[12] = '{1'b1, 3'd5, 32'hFFFF_FFFF,  32'd50000};
      vec[13] = '{1'b0, 3'd5, 32'h0,          32'h000F_FFFF};
      vec[14] = '{1'b1, 3'd6, 32'h0000_1234,  32'h0};
      vec[15] = '{1'b0, 3'd6, 32'h0,          32'h0};
      vec[16] = '{1'b1, 3'd3, 32'h0000_000F,  32'h0};
      vec[17] = '{1'b0, 3'd3, 32'h0,          32'h0};

      ticks(3);
      reset = 1'b0;
      check("reset_irq", {31'b0, irq}, 32'h0);

      for (int i = 0; i < NVEC; i++) begin
         bus_if.address   = vec[i].addr;
         bus_if.writedata = vec[i].wdata;
         bus_if.write     = vec[i].wr;
         bus_if.read      = 1'b1;
         tick();
         bus_if.write     = 1'b0;
         bus_if.read      = 1'b0;
         check($sformatf("vec%0d_%s_a%0d", i, vec[i].wr ? "wr" : "rd", vec[i].addr),
               bus_if.readdata, vec[i].exp);
      end

      // Restore defaults for the directed sequences.
      bus_wr(3'd2, 32'h0);
      bus_wr(3'd4, 32'h1);
      bus_wr(3'd5, 32'd8);

      // Debounce latency with DBRELOAD=8: pin driven after edge c0, sync2 at
      // c0+2, count 1..7 over c0+3..c0+9, stable at c0+10, DATA read at c0+11.
      bus_if.address = 3'd0;
      tick();
      c0 = cyc;
      in_port = 4'h5;
      found = 1'b0;
      lat = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (bus_if.readdata == 32'h5) begin
            found = 1'b1;
            lat = cyc - c0;
         end
      end
      check("db_found", {31'b0, found}, 32'h1);
      check("db_latency", lat, 32'd11);
      ticks(10);
      rd_check("db_edgecap", 3'd3, 32'h5);

      // Glitch rejection: 5-cycle pulse is shorter than DBRELOAD=8.
      in_port = 4'h0;
      ticks(20);
      bus_wr(3'd3, 32'hF);
      in_port = 4'h1;
      ticks(5);
      in_port = 4'h0;
      ticks(20);
      rd_check("glitch_data", 3'd0, 32'h0);
      rd_check("glitch_edgecap", 3'd3, 32'h0);

      // Interrupt on both edges with debounce bypassed.
      bus_wr(3'd2, 32'h1);
      bus_wr(3'd4, 32'h3);
      bus_wr(3'd5, 32'h0);
      in_port = 4'h1;
      ticks(6);
      check("irq_rise", {31'b0, irq}, 32'h1);
      rd_check("irq_rise_edgecap", 3'd3, 32'h1);
      bus_wr(3'd3, 32'h1);
      check("irq_hold_after_w1c", {31'b0, irq}, 32'h1);
      tick();
      check("irq_cleared", {31'b0, irq}, 32'h0);
      in_port = 4'h0;
      ticks(6);
      check("irq_fall", {31'b0, irq}, 32'h1);
      rd_check("irq_fall_edgecap", 3'd3, 32'h1);

      // Set wins over W1C: pin driven after edge c0, stable at c0+3, edge
      // captured at c0+4, which is the edge the W1C write lands on.
      bus_wr(3'd3, 32'hF);
      in_port = 4'h2;
      ticks(3);
      bus_wr(3'd3, 32'h2);
      rd_check("set_beats_clear", 3'd3, 32'h2);
      bus_wr(3'd3, 32'h2);
      rd_check("w1c_alone", 3'd3, 32'h0);

      // Reset during a debounce.
      bus_wr(3'd2, 32'h0);
      bus_wr(3'd4, 32'h1);
      bus_wr(3'd5, 32'd8);
      in_port = 4'h0;
      ticks(20);
      bus_wr(3'd3, 32'hF);
      in_port = 4'h1;
      ticks(7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      c0 = cyc;
      check("rst_irq", {31'b0, irq}, 32'h0);
      rd_check("rst_data", 3'd0, 32'h0);
      rd_check("rst_irqmask", 3'd2, 32'h0);
      rd_check("rst_edgecap", 3'd3, 32'h0);
      rd_check("rst_edgesel", 3'd4, 32'h1);
      rd_check("rst_dbreload", 3'd5, 32'd50000);

      // Re-debounce from reset edge c0: sync2 at c0+2, count reaches 49999
      // at c0+50001, stable at c0+50002, DATA read at c0+50003.
      bus_if.address = 3'd0;
      found = 1'b0;
      lat = 0;
      for (int i = 0; i < 50100 && !found; i++) begin
         tick();
         if (bus_if.readdata == 32'h1) begin
            found = 1'b1;
            lat = cyc - c0;
         end
      end
      check("rst_redb_found", {31'b0, found}, 32'h1);
      check("rst_redb_latency", lat, 32'd50003);
      ticks(2);
      rd_check("rst_redb_edgecap", 3'd3, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_control_pio_ctrl
